// File: rtl/mem_stream_writer_pkg.sv
// Shared types and helpers for the byte-stream memory writer.
// Imported by the packer and the top-level controller.
package mem_stream_writer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } writer_state_t;

    function automatic int bpw(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/mem_stream_writer_byte_packer.sv
// Packs accepted bytes little-endian into WIDTH-bit words and
// emits a registered one-cycle word_valid with the finished word.
import mem_stream_writer_pkg::*;

module byte_packer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             accept,
    input  logic [7:0]       in_data,
    output logic             last,
    output logic             word_valid,
    output logic [WIDTH-1:0] word
);

    localparam int BPW = bpw(WIDTH);
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] pack;
    logic [WIDTH-1:0] merged;

    assign last = accept && (idx == LAST_IDX);

    always_comb begin
        merged = pack;
        merged[8*idx +: 8] = in_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            pack       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx  <= '0;
                pack <= '0;
            end else if (accept) begin
                if (last) begin
                    word       <= merged;
                    word_valid <= 1'b1;
                    idx        <= '0;
                    pack       <= '0;
                end else begin
                    pack <= merged;
                    idx  <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_stream_writer.sv
// Streams bytes into a single-port memory as packed words, starting
// at a latched base address; pulses done when word_count words land.
import mem_stream_writer_pkg::*;

module mem_stream_writer #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      word_count,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_data,
    output logic             mem_we,
    output logic             busy,
    output logic             done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    writer_state_t state;
    writer_state_t state_next;

    logic [AW-1:0] addr;
    logic [AW:0]   count;
    logic [AW:0]   wcnt;
    logic          accept;
    logic          last;
    logic          clear;
    logic          final_word;

    assign accept     = in_valid && in_ready;
    assign clear      = (state == IDLE) && start;
    assign final_word = ((wcnt + 1'b1) == count);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start)
                       state_next = (word_count == '0) ? DONE : LOAD;
            LOAD:  if (last && final_word)
                       state_next = FLUSH;
            FLUSH: state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    // Address/count latch; mem_addr tracks the word the packer is emitting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            count    <= '0;
            wcnt     <= '0;
            mem_addr <= '0;
        end else if (clear) begin
            addr  <= base_addr;
            count <= word_count;
            wcnt  <= '0;
        end else if (last) begin
            mem_addr <= addr;
            addr     <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            wcnt     <= wcnt + 1'b1;
        end
    end

    byte_packer #(
        .WIDTH(WIDTH)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .accept     (accept),
        .in_data    (in_data),
        .last       (last),
        .word_valid (mem_we),
        .word       (mem_data)
    );

endmodule

// File: tb/tb_mem_stream_writer.sv
// Scoreboard bench: expected writes are queued as bytes are accepted
// and checked by per-DUT monitors as mem_we appears.
module tb_mem_stream_writer;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    int vectors;
    int miscompares;
    int cyc;
    exp_t q16[$];
    exp_t q8[$];

    logic clock;
    logic reset;

    logic        start16, in_valid16, in_ready16, mem_we16, busy16, done16;
    logic [7:0]  base16, in_data16, mem_addr16;
    logic [8:0]  count16;
    logic [15:0] mem_data16;

    logic        start8, in_valid8, in_ready8, mem_we8, busy8, done8;
    logic [7:0]  base8, in_data8, mem_addr8, mem_data8;
    logic [8:0]  count8;

    mem_stream_writer #(.WIDTH(16), .DEPTH(256)) dut16 (
        .clock(clock), .reset(reset), .start(start16),
        .base_addr(base16), .word_count(count16),
        .in_data(in_data16), .in_valid(in_valid16), .in_ready(in_ready16),
        .mem_addr(mem_addr16), .mem_data(mem_data16), .mem_we(mem_we16),
        .busy(busy16), .done(done16)
    );

    mem_stream_writer #(.WIDTH(8), .DEPTH(256)) dut8 (
        .clock(clock), .reset(reset), .start(start8),
        .base_addr(base8), .word_count(count8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .mem_addr(mem_addr8), .mem_data(mem_data8), .mem_we(mem_we8),
        .busy(busy8), .done(done8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        exp_t e;
        if (mem_we16) begin
            vectors++;
            if (q16.size() == 0) begin
                miscompares++;
                $display("FAIL wr16_unexpected addr=%h data=%h cyc=%0d",
                         mem_addr16, mem_data16, cyc);
            end else begin
                e = q16.pop_front();
                if (mem_addr16 !== e.addr || mem_data16 !== e.data || cyc !== e.cyc) begin
                    miscompares++;
                    $display("FAIL wr16 got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                             mem_addr16, mem_data16, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        if (mem_we8) begin
            vectors++;
            if (q8.size() == 0) begin
                miscompares++;
                $display("FAIL wr8_unexpected addr=%h data=%h cyc=%0d",
                         mem_addr8, mem_data8, cyc);
            end else begin
                e = q8.pop_front();
                if (mem_addr8 !== e.addr || {8'h00, mem_data8} !== e.data || cyc !== e.cyc) begin
                    miscompares++;
                    $display("FAIL wr8 got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                             mem_addr8, mem_data8, cyc, e.addr, e.data[7:0], e.cyc);
                end
            end
        end
    end

    task automatic start16_load(input logic [7:0] b, input logic [8:0] n);
        start16 = 1'b1; base16 = b; count16 = n;
        @(posedge clock); #1;
        start16 = 1'b0; base16 = 8'h00; count16 = 9'd0;
    endtask

    // Drives one byte for one cycle; queues a write if it completes a word.
    task automatic send16(input logic [7:0] d, input logic push,
                          input logic [7:0] a, input logic [15:0] w);
        exp_t e;
        in_data16 = d; in_valid16 = 1'b1;
        @(posedge clock); #1;
        in_valid16 = 1'b0;
        if (push) begin
            e.addr = a; e.data = w; e.cyc = cyc;
            q16.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        vectors++;
        if ({in_ready16, mem_we16, busy16, done16} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_ctl16 got %b want 0000",
                     {in_ready16, mem_we16, busy16, done16});
        end
        vectors++;
        if (mem_addr16 !== 8'h00 || mem_data16 !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mem16 got %h/%h want 00/0000", mem_addr16, mem_data16);
        end
        vectors++;
        if ({in_ready8, mem_we8, busy8, done8, mem_addr8, mem_data8} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_dut8 got %h want 0",
                     {in_ready8, mem_we8, busy8, done8, mem_addr8, mem_data8});
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int dn;
        logic busy_at, busy_after, prev;
        start16_load(8'h10, 9'd2);
        vectors++;
        if (busy16 !== 1'b1 || in_ready16 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_busy got busy=%b rdy=%b want 1/1", busy16, in_ready16);
        end
        in_data16 = 8'h11; in_valid16 = 1'b1;
        @(posedge clock); #1;
        send16(8'h22, 1'b1, 8'h10, 16'h2211);
        in_data16 = 8'h33; in_valid16 = 1'b1;
        @(posedge clock); #1;
        send16(8'h44, 1'b1, 8'h11, 16'h4433);
        dn = 0; prev = 1'b0; busy_at = 1'b0; busy_after = 1'b1;
        repeat (8) begin
            @(negedge clock);
            if (done16) begin dn++; busy_at = busy16; end
            else if (prev) busy_after = busy16;
            prev = done16;
        end
        vectors++;
        if (dn !== 1) begin
            miscompares++;
            $display("FAIL b2b_done_pulses got %0d want 1", dn);
        end
        vectors++;
        if (busy_at !== 1'b1 || busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_busy_fall got %b%b want 10", busy_at, busy_after);
        end
        vectors++;
        if (q16.size() !== 0) begin
            miscompares++;
            $display("FAIL b2b_missing got %0d pending want 0", q16.size());
        end
    endtask

    task automatic test_gaps();
        logic rdy_ok;
        rdy_ok = 1'b1;
        start16_load(8'h30, 9'd2);
        send16(8'h11, 1'b0, 8'h00, 16'h0);
        repeat (2) begin
            @(negedge clock);
            rdy_ok = rdy_ok & in_ready16;
            @(posedge clock); #1;
        end
        send16(8'h22, 1'b1, 8'h30, 16'h2211);
        send16(8'h33, 1'b0, 8'h00, 16'h0);
        repeat (2) begin
            @(negedge clock);
            rdy_ok = rdy_ok & in_ready16;
            @(posedge clock); #1;
        end
        send16(8'h44, 1'b1, 8'h31, 16'h4433);
        repeat (4) @(posedge clock);
        #1;
        vectors++;
        if (rdy_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps_ready got %b want 1", rdy_ok);
        end
        vectors++;
        if (q16.size() !== 0) begin
            miscompares++;
            $display("FAIL gaps_missing got %0d pending want 0", q16.size());
        end
    endtask

    task automatic test_zero_count();
        int dn;
        logic rdy_seen;
        dn = 0; rdy_seen = 1'b0;
        in_valid16 = 1'b1; in_data16 = 8'hEE;
        start16_load(8'h50, 9'd0);
        repeat (6) begin
            @(negedge clock);
            if (done16) dn++;
            rdy_seen = rdy_seen | in_ready16;
        end
        in_valid16 = 1'b0;
        vectors++;
        if (dn !== 1) begin
            miscompares++;
            $display("FAIL zero_done got %0d want 1", dn);
        end
        vectors++;
        if (rdy_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_ready got %b want 0", rdy_seen);
        end
        vectors++;
        if (busy16 !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_busy got %b want 0", busy16);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int dn;
        start8 = 1'b1; base8 = 8'hFF; count8 = 9'd2;
        @(posedge clock); #1;
        start8 = 1'b0; base8 = 8'h00; count8 = 9'd0;
        in_data8 = 8'hAA; in_valid8 = 1'b1;
        @(posedge clock); #1;
        e.addr = 8'hFF; e.data = 16'h00AA; e.cyc = cyc; q8.push_back(e);
        in_data8 = 8'hBB;
        @(posedge clock); #1;
        in_valid8 = 1'b0;
        e.addr = 8'h00; e.data = 16'h00BB; e.cyc = cyc; q8.push_back(e);
        dn = 0;
        repeat (5) begin
            @(negedge clock);
            if (done8) dn++;
        end
        vectors++;
        if (dn !== 1 || q8.size() !== 0) begin
            miscompares++;
            $display("FAIL wrap_end got done=%0d pending=%0d want 1/0", dn, q8.size());
        end
    endtask

    task automatic test_reset_mid();
        start16_load(8'h80, 9'd2);
        send16(8'h99, 1'b0, 8'h00, 16'h0);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({in_ready16, mem_we16, busy16, done16} !== 4'b0) begin
            miscompares++;
            $display("FAIL rstmid_ctl got %b want 0000",
                     {in_ready16, mem_we16, busy16, done16});
        end
        vectors++;
        if (mem_addr16 !== 8'h00 || mem_data16 !== 16'h0000) begin
            miscompares++;
            $display("FAIL rstmid_mem got %h/%h want 00/0000", mem_addr16, mem_data16);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        start16_load(8'h00, 9'd1);
        send16(8'h55, 1'b0, 8'h00, 16'h0);
        send16(8'h66, 1'b1, 8'h00, 16'h6655);
        repeat (4) @(posedge clock);
        #1;
        vectors++;
        if (q16.size() !== 0 || busy16 !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_reload got pending=%0d busy=%b want 0/0",
                     q16.size(), busy16);
        end
    endtask

    task automatic test_start_ignored();
        start16_load(8'h20, 9'd2);
        send16(8'h01, 1'b0, 8'h00, 16'h0);
        start16 = 1'b1; base16 = 8'h40; count16 = 9'd1;
        send16(8'h02, 1'b1, 8'h20, 16'h0201);
        start16 = 1'b0;
        send16(8'h03, 1'b0, 8'h00, 16'h0);
        start16 = 1'b1;
        send16(8'h04, 1'b1, 8'h21, 16'h0403);
        start16 = 1'b0; base16 = 8'h00; count16 = 9'd0;
        vectors++;
        if (in_ready16 !== 1'b0 || busy16 !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_flush got rdy=%b busy=%b want 0/1", in_ready16, busy16);
        end
        repeat (4) @(posedge clock);
        #1;
        vectors++;
        if (q16.size() !== 0 || busy16 !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_end got pending=%0d busy=%b want 0/0",
                     q16.size(), busy16);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        start16 = 0; base16 = 0; count16 = 0; in_data16 = 0; in_valid16 = 0;
        start8 = 0; base8 = 0; count8 = 0; in_data8 = 0; in_valid8 = 0;
        reset = 1'b0;
        #2;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_zero_count();
        test_wrap();
        test_reset_mid();
        test_start_ignored();
        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
